udcnt_ctrl: RTL and testbench

Front-end control stage directly upstream of the 4-bit up/down counter (udcnt). It converts two raw, asynchronous, bouncy push-button inputs into the counter's control signals: single-cycle count pulses on i and a toggled direction level on u_d. It performs synchronisation, debouncing and edge detection, and generates hold-to-repeat count pulses.

---
 rtl/udcnt_pkg.sv | 13 +
 rtl/btn_debounce.sv | 55 +++++
 rtl/udcnt_ctrl.sv | 122 ++++++++++++
 tb/tb_udcnt_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/udcnt_pkg.sv
// Shared types and constants for the up/down counter front-end control stage.
package udcnt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        REPEAT
    } cnt_state_t;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

endpackage

// File: rtl/btn_debounce.sv
// One push-button path: multi-stage synchroniser, stable-count debouncer and
// rising-edge detector on the accepted (debounced) level.
module btn_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_x;
    logic [CW-1:0]          db_cnt_reg, db_cnt_next;
    logic                   stable_reg, stable_next;
    logic                   stable_d_reg;

    assign sync_x = sync_reg[SYNC_STAGES-1];

    // A new level is accepted only after DB_CYCLES consecutive differing samples.
    always_comb begin
        db_cnt_next = '0;
        stable_next = stable_reg;
        if (sync_x != stable_reg) begin
            if (db_cnt_reg == DB_LAST) begin
                stable_next = sync_x;
            end else begin
                db_cnt_next = db_cnt_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg     <= '0;
            db_cnt_reg   <= '0;
            stable_reg   <= 1'b0;
            stable_d_reg <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], btn_raw};
            db_cnt_reg   <= db_cnt_next;
            stable_reg   <= stable_next;
            stable_d_reg <= stable_reg;
        end
    end

    assign level = stable_reg;
    assign rise  = stable_reg & ~stable_d_reg;

endmodule

// File: rtl/udcnt_ctrl.sv
// Converts the raw count/direction buttons into registered count pulses (with
// hold-to-repeat) and a toggled direction level for the downstream udcnt.
module udcnt_ctrl
    import udcnt_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   DB_CYCLES     = 4,
    parameter int   REPEAT_DELAY  = 16,
    parameter int   REPEAT_PERIOD = 8,
    parameter logic U_D_INIT      = UP
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_cnt,
    input  logic btn_dir,
    output logic i,
    output logic u_d,
    output logic cnt_held
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RW-1:0] RD_LAST = (REPEAT_DELAY > 0) ? RW'(REPEAT_DELAY - 1) : '0;
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    // Bit 0 = count button, bit 1 = direction button.
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_rise;
    logic       unused_dir_level;

    assign btn_raw          = {btn_dir, btn_cnt};
    assign unused_dir_level = btn_level[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        btn_debounce #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(btn_raw[gi]),
            .level  (btn_level[gi]),
            .rise   (btn_rise[gi])
        );
    end

    cnt_state_t    state_reg, state_next;
    logic [RW-1:0] rpt_cnt_reg, rpt_cnt_next;
    logic          i_reg, i_next;
    logic          u_d_reg, u_d_next;
    logic          level_cnt, rise_cnt, rise_dir;

    assign level_cnt = btn_level[0];
    assign rise_cnt  = btn_rise[0];
    assign rise_dir  = btn_rise[1];

    always_comb begin
        state_next   = state_reg;
        rpt_cnt_next = rpt_cnt_reg;
        i_next       = 1'b0;
        u_d_next     = u_d_reg ^ rise_dir;
        if (!level_cnt) begin
            // Release from any state aborts silently.
            state_next   = IDLE;
            rpt_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rise_cnt) begin
                        i_next       = 1'b1;
                        rpt_cnt_next = '0;
                        state_next   = FIRST;
                    end
                end
                FIRST: begin
                    // With REPEAT_DELAY == 0 the FSM parks here until release.
                    if (REPEAT_DELAY != 0) begin
                        if (rpt_cnt_reg == RD_LAST) begin
                            i_next       = 1'b1;
                            rpt_cnt_next = '0;
                            state_next   = REPEAT;
                        end else begin
                            rpt_cnt_next = rpt_cnt_reg + RW'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (rpt_cnt_reg == RP_LAST) begin
                        i_next       = 1'b1;
                        rpt_cnt_next = '0;
                    end else begin
                        rpt_cnt_next = rpt_cnt_reg + RW'(1);
                    end
                end
                default: begin
                    state_next   = IDLE;
                    rpt_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            rpt_cnt_reg <= '0;
            i_reg       <= 1'b0;
            u_d_reg     <= U_D_INIT;
        end else begin
            state_reg   <= state_next;
            rpt_cnt_reg <= rpt_cnt_next;
            i_reg       <= i_next;
            u_d_reg     <= u_d_next;
        end
    end

    assign i        = i_reg;
    assign u_d      = u_d_reg;
    assign cnt_held = level_cnt;

endmodule

// File: tb/tb_udcnt_ctrl.sv
// Directed bench for udcnt_ctrl with default parameters; edge numbers count
// rising edges from the first one that samples the new button value.
module tb_udcnt_ctrl;

    logic clk;
    logic rst;
    logic btn_cnt;
    logic btn_dir;
    logic i;
    logic u_d;
    logic cnt_held;

    int checks = 0;
    int errors = 0;
    int pulses;
    logic [3:0] cnt4;

    udcnt_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .btn_cnt (btn_cnt),
        .btn_dir (btn_dir),
        .i       (i),
        .u_d     (u_d),
        .cnt_held(cnt_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive buttons, advance one rising edge, sample 1 time unit later.
    // cnt4 models the downstream udcnt, which samples i/u_d at the edge.
    task automatic tick(input logic bc, input logic bd);
        logic p_i, p_ud;
        p_i     = i;
        p_ud    = u_d;
        btn_cnt = bc;
        btn_dir = bd;
        @(posedge clk);
        #1;
        if (p_i && rst) cnt4 = p_ud ? cnt4 + 4'd1 : cnt4 - 4'd1;
        if (i) pulses++;
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0);
    endtask

    initial begin
        rst     = 1'b0;
        btn_cnt = 1'b1;
        btn_dir = 1'b1;
        cnt4    = 4'd0;
        pulses  = 0;

        // Reset holds everything regardless of pressed buttons.
        for (int k = 1; k <= 3; k++) begin
            tick(1'b1, 1'b1);
            chk("rst_i", i, 1'b0);
            chk("rst_held", cnt_held, 1'b0);
            chk("rst_ud", u_d, 1'b1);
        end
        tick(1'b0, 1'b0);
        rst = 1'b1;
        settle(6);
        chk("idle_i", i, 1'b0);
        $display("reset: i=%b cnt_held=%b u_d=%b", i, cnt_held, u_d);

        // Clean press of 10 cycles.
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(k <= 10, 1'b0);
            chk("clean_i", i, k == 7);
            chk("clean_held", cnt_held, (k >= 6) && (k <= 15));
        end
        settle(4);
        chk4("clean_pulses", 4'(pulses), 4'd1);
        chk4("clean_count", cnt4, 4'd1);
        $display("clean press: pulses=%0d count=%0d", pulses, cnt4);

        // Bounce 1,0,1,0 then steady 1 from edge 5.
        pulses = 0;
        for (int k = 1; k <= 14; k++) begin
            tick((k <= 4) ? ((k % 2) == 1) : 1'b1, 1'b0);
            chk("bounce_i", i, k == 11);
        end
        settle(12);
        chk4("bounce_pulses", 4'(pulses), 4'd1);
        chk4("bounce_count", cnt4, 4'd2);
        $display("bounce: pulses=%0d count=%0d", pulses, cnt4);

        // A 3-cycle glitch is rejected.
        pulses = 0;
        for (int k = 1; k <= 18; k++) begin
            tick(k <= 3, 1'b0);
            chk("glitch_i", i, 1'b0);
            chk("glitch_held", cnt_held, 1'b0);
        end
        chk4("glitch_pulses", 4'(pulses), 4'd0);
        $display("glitch: pulses=%0d", pulses);

        // Auto-repeat: held 50 cycles.
        pulses = 0;
        for (int k = 1; k <= 70; k++) begin
            tick(k <= 50, 1'b0);
            chk("rpt_i", i, (k == 7) || (k == 23) || (k == 31) ||
                            (k == 39) || (k == 47) || (k == 55));
        end
        chk4("rpt_pulses", 4'(pulses), 4'd6);
        chk4("rpt_count", cnt4, 4'd8);
        $display("auto-repeat: pulses=%0d count=%0d", pulses, cnt4);

        // Two separate direction presses (second press starts at edge 26).
        for (int k = 1; k <= 50; k++) begin
            tick(1'b0, ((k >= 1) && (k <= 10)) || ((k >= 26) && (k <= 35)));
            chk("dir_ud", u_d, (k < 7) || (k >= 32));
            chk("dir_i", i, 1'b0);
        end
        $display("direction: u_d=%b", u_d);

        // Simultaneous press: toggle and pulse on the same edge, step is Down.
        pulses = 0;
        for (int k = 1; k <= 25; k++) begin
            tick(k <= 10, k <= 10);
            chk("sim_i", i, k == 7);
            chk("sim_ud", u_d, k < 7);
        end
        settle(3);
        chk4("sim_count", cnt4, 4'd7);
        $display("simultaneous: u_d=%b count=%0d", u_d, cnt4);

        // Reset asserted in REPEAT with button held (u_d is currently 0).
        for (int k = 1; k <= 32; k++) begin
            tick(1'b1, 1'b0);
            chk("mid_i", i, (k == 7) || (k == 23) || (k == 31));
        end
        rst = 1'b0;
        #1;
        chk("mid_rst_i", i, 1'b0);
        chk("mid_rst_held", cnt_held, 1'b0);
        chk("mid_rst_ud", u_d, 1'b1);
        tick(1'b1, 1'b0);
        chk("mid_rst_i2", i, 1'b0);
        tick(1'b1, 1'b0);
        chk("mid_rst_i3", i, 1'b0);
        rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1'b1, 1'b0);
            chk("post_rst_i", i, k == 7);
            chk("post_rst_ud", u_d, 1'b1);
        end
        settle(10);
        chk("end_held", cnt_held, 1'b0);
        $display("reset mid-repeat: i=%b u_d=%b", i, u_d);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
